led_serializer: RTL

LED_SERIALIZER -- requirements
Module: led_serializer

---
 rtl/led_serializer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/led_serializer.sv
// LED frame serializer: buffers one pending pattern, shifts a frame out on
// sdo after a start pulse, and pulses latch when the frame-end strobe lines
// up with the last bit. A strobe that arrives early sets a sticky error.
module led_serializer #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             str,
    input  logic [WIDTH-1:0] pat_in,
    input  logic             pat_valid,
    output logic             pat_ready,
    output logic             sdo,
    output logic             latch,
    output logic             busy,
    output logic             err,
    output logic [7:0]       frame_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [4:0] LAST_BIT = 5'(WIDTH - 1);

    state_t           state_reg;
    state_t           state_next;

    logic [WIDTH-1:0] pending_reg;
    logic             pend_full_reg;
    logic [WIDTH-1:0] shreg_reg;
    logic [WIDTH-1:0] frame_reg;    // unshifted copy of the word being sent
    logic [WIDTH-1:0] disp_reg;
    logic [4:0]       bit_cnt_reg;
    logic             sdo_reg;
    logic             latch_reg;
    logic             err_reg;
    logic [7:0]       frame_cnt_reg;

    logic             accept;
    logic [WIDTH-1:0] load_word;
    logic [WIDTH-1:0] shreg_shifted;
    logic             load_bit;
    logic             shift_bit;
    logic             at_last;

    // A start uses the pre-edge buffer contents; a same-edge accept refills it.
    assign accept    = pat_valid && !pend_full_reg;
    assign load_word = pend_full_reg ? pending_reg : disp_reg;
    assign at_last   = (bit_cnt_reg == LAST_BIT);

    // Shift direction and output-end bit selection depend on bit order.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shreg_shifted = {shreg_reg[WIDTH-2:0], 1'b0};
            assign load_bit      = load_word[WIDTH-1];
            assign shift_bit     = shreg_reg[WIDTH-2];
        end else begin : g_lsb_first
            assign shreg_shifted = {1'b0, shreg_reg[WIDTH-1:1]};
            assign load_bit      = load_word[0];
            assign shift_bit     = shreg_reg[1];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: start always (re)enters SHIFT; any strobe in SHIFT ends the frame.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (start) begin
                    state_next = SHIFT;
                end else if (str) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pending buffer: accept when empty, drained by start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg   <= '0;
            pend_full_reg <= 1'b0;
        end else begin
            if (accept) begin
                pending_reg   <= pat_in;
                pend_full_reg <= 1'b1;
            end else if (start) begin
                pend_full_reg <= 1'b0;
            end
        end
    end

    // Frame datapath: load, shift, hold on last bit, latch or flag error on strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_reg     <= '0;
            frame_reg     <= '0;
            disp_reg      <= '0;
            bit_cnt_reg   <= '0;
            sdo_reg       <= 1'b0;
            latch_reg     <= 1'b0;
            err_reg       <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            latch_reg <= 1'b0;
            if (start) begin
                shreg_reg   <= load_word;
                frame_reg   <= load_word;
                bit_cnt_reg <= '0;
                sdo_reg     <= load_bit;
            end else if (state_reg == SHIFT) begin
                if (str) begin
                    if (at_last) begin
                        latch_reg     <= 1'b1;
                        disp_reg      <= frame_reg;
                        frame_cnt_reg <= frame_cnt_reg + 8'd1;
                    end else begin
                        err_reg <= 1'b1;
                    end
                    sdo_reg <= 1'b0;
                end else if (!at_last) begin
                    shreg_reg   <= shreg_shifted;
                    bit_cnt_reg <= bit_cnt_reg + 5'd1;
                    sdo_reg     <= shift_bit;
                end
            end
        end
    end

    assign pat_ready = ~pend_full_reg;
    assign sdo       = sdo_reg;
    assign latch     = latch_reg;
    assign busy      = (state_reg == SHIFT);
    assign err       = err_reg;
    assign frame_cnt = frame_cnt_reg;

endmodule
